// File: rtl/radix2_divider.sv
// Signed restoring radix-2 divider, one quotient bit per clock.
// Operands are converted to magnitudes at start, divided unsigned MSB-first,
// then the signs are reapplied in a single fix-up cycle. Results match
// Verilog signed a/b and a%b (truncation toward zero).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      launch request, honoured only in IDLE or DONE
//   a, b       signed dividend / divisor, captured on the accepted start edge
//   quotient   signed quotient (registered)
//   remainder  signed remainder (registered)
//   flag       1 = result valid and block idle, 0 = busy or no result yet
//   div_zero   last operation had b == 0
//   ovf        last operation was -2^(N-1) / -1
module radix2_divider #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         flag,
  output logic         div_zero,
  output logic         ovf
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [N-1:0]   dvd, dvd_nx;        // dividend magnitude, refilled with quotient bits
  logic [N-1:0]   dsr, dsr_nx;        // divisor magnitude
  logic [N-1:0]   prem, prem_nx;      // partial remainder
  logic [CW-1:0]  cnt, cnt_nx;
  logic           sign_q, sign_q_nx;
  logic           sign_r, sign_r_nx;
  logic           ovf_case, ovf_case_nx;
  logic [N-1:0]   quotient_nx, remainder_nx;
  logic           flag_nx, div_zero_nx, ovf_nx;

  logic [N:0]     shifted_c;
  logic [N:0]     trial_c;
  logic [N-1:0]   abs_a_c, abs_b_c;
  logic           min_a_c;

  // Per-step restoring datapath and operand magnitudes
  always_comb begin
    shifted_c = {prem, dvd[N-1]};
    trial_c   = shifted_c - {1'b0, dsr};
    abs_a_c   = a[N-1] ? N'(-a) : a;
    abs_b_c   = b[N-1] ? N'(-b) : b;
    min_a_c   = (a == {1'b1, {(N-1){1'b0}}});
  end

  // Next-state and next-register logic
  always_comb begin
    state_nx     = state;
    dvd_nx       = dvd;
    dsr_nx       = dsr;
    prem_nx      = prem;
    cnt_nx       = cnt;
    sign_q_nx    = sign_q;
    sign_r_nx    = sign_r;
    ovf_case_nx  = ovf_case;
    quotient_nx  = quotient;
    remainder_nx = remainder;
    flag_nx      = flag;
    div_zero_nx  = div_zero;
    ovf_nx       = ovf;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          if (b == '0) begin
            // Divide by zero resolves immediately without iterating
            quotient_nx  = '1;
            remainder_nx = a;
            div_zero_nx  = 1'b1;
            ovf_nx       = 1'b0;
            flag_nx      = 1'b1;
            state_nx     = DONE;
          end else begin
            dvd_nx       = abs_a_c;
            dsr_nx       = abs_b_c;
            sign_q_nx    = a[N-1] ^ b[N-1];
            sign_r_nx    = a[N-1];
            ovf_case_nx  = min_a_c && (b == '1);
            prem_nx      = '0;
            cnt_nx       = '0;
            flag_nx      = 1'b0;
            div_zero_nx  = 1'b0;
            ovf_nx       = 1'b0;
            state_nx     = CALC;
          end
        end
      end

      CALC: begin
        // Negative trial (MSB set) means restore and shift in a 0
        prem_nx = trial_c[N] ? shifted_c[N-1:0] : trial_c[N-1:0];
        dvd_nx  = {dvd[N-2:0], ~trial_c[N]};
        cnt_nx  = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nx = FIX;
        end
      end

      FIX: begin
        quotient_nx  = sign_q ? N'(-dvd) : dvd;
        remainder_nx = sign_r ? N'(-prem) : prem;
        flag_nx      = 1'b1;
        ovf_nx       = ovf_case;
        state_nx     = DONE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dvd       <= '0;
      dsr       <= '0;
      prem      <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      ovf_case  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      flag      <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nx;
      dvd       <= dvd_nx;
      dsr       <= dsr_nx;
      prem      <= prem_nx;
      cnt       <= cnt_nx;
      sign_q    <= sign_q_nx;
      sign_r    <= sign_r_nx;
      ovf_case  <= ovf_case_nx;
      quotient  <= quotient_nx;
      remainder <= remainder_nx;
      flag      <= flag_nx;
      div_zero  <= div_zero_nx;
      ovf       <= ovf_nx;
    end
  end

endmodule

// File: doc/radix2_divider.md
RADIX2_DIVIDER -- requirements
Module: radix2_divider

Interface
REQ-001 Parameter: N, 16, operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 start  input  1  request pulse/level; sampled only in IDLE or DONE.
REQ-005 a  input  N  signed dividend; sampled on the accepted start edge.
REQ-006 b  input  N  signed divisor; sampled on the accepted start edge.
REQ-007 quotient  output  N  signed quotient, registered.
REQ-008 remainder  output  N  signed remainder, registered.
REQ-009 flag  output  1  1 = result valid / block idle-with-result; 0 = busy or no result.
REQ-010 div_zero  output  1  1 = last operation had b == 0.
REQ-011 ovf  output  1  1 = last operation was a = -2^(N-1), b = -1.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE.
REQ-013 Start acceptance: start = 1 in IDLE or DONE at a rising edge SHALL begin an operation; start in CALC/FIX SHALL be ignored.
REQ-014 On accepted start with b != 0: latch |a|, |b| as N-bit unsigned, sign_q = a[N-1]^b[N-1], sign_r = a[N-1], clear partial remainder and bit counter, flag=0, div_zero=0, ovf=0, go to CALC.
REQ-015 CALC: one quotient bit per cycle, MSB first; shift {partial remainder, dividend} left by 1, trial-subtract |b| at N+1 bits, keep the result and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-016 CALC SHALL last exactly N cycles (counter 0..N-1), then go to FIX.
REQ-017 FIX (one cycle): quotient = sign_q ? -Q : Q, remainder = sign_r ? -R : R, both truncated to N bits; flag=1; ovf set per REQ-011; go to DONE.
REQ-018 Latency: flag rises at the edge N+1 cycles after the accepted start edge (N=16: 17 cycles); flag is 0 for the N cycles in between.
REQ-019 Results SHALL equal Verilog signed a/b and a%b: truncation toward zero, remainder sign follows dividend, |remainder| < |b|.
REQ-020 Overflow case a = -2^(N-1), b = -1: quotient = -2^(N-1) (wrapped), remainder = 0, ovf = 1.
REQ-021 Divide by zero: on the accepted start edge, quotient = all ones, remainder = a, div_zero = 1, flag = 1, state = DONE (1-cycle latency, no CALC).
REQ-022 DONE: outputs and flags SHALL hold until the next accepted start or reset.
REQ-023 quotient/remainder SHALL hold their previous values during CALC and FIX; only the FIX edge (or a div-by-zero start) updates them.
REQ-024 a and b changes after the start edge SHALL NOT affect the running operation.
REQ-025 Back-to-back: start held high in DONE SHALL immediately launch the next operation, flag falling on that edge.

Reset
REQ-026 reset = 0 SHALL asynchronously force state = IDLE, quotient = 0, remainder = 0, flag = 0, div_zero = 0, ovf = 0, and clear all internal registers.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; after release, the block SHALL require a new start.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-029 a=100, b=7, start 1 cycle -> flag 0 for 16 cycles, then flag=1, quotient=14, remainder=2, div_zero=0, ovf=0.
REQ-030 Sign cases (N=16): -100/7 -> -14 r -2; 100/-7 -> -14 r 2; -100/-7 -> 14 r -2.
REQ-031 a=-32768, b=-1 -> quotient=-32768, remainder=0, ovf=1, flag after 17 cycles; a=-32768, b=1 -> -32768 r 0, ovf=0.
REQ-032 a=1234, b=0 -> next edge flag=1, quotient=16'hFFFF, remainder=1234, div_zero=1.
REQ-033 start held during CALC, plus reset pulsed at cycle 8 of CALC -> start ignored while busy; on reset all outputs 0 immediately; new start after release gives the correct result.
REQ-034 64 random signed pairs (b != 0), back-to-back starts -> every result matches a/b and a%b, and every flag-low count equals 16.
